// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared constants, encodings and decode helpers for the mc_core multicycle processor
//
// Holds the opcode values, instruction field positions, the FSM state enum and
// the ALU operation encoding. Imported by mc_alu and mc_core.
package mc_pkg;

  localparam int REG_ADDRESS_SIZE = 2;
  localparam int INSTR_W          = 20;

  // Instruction field positions within bits [19:0] of a fetched word
  localparam int OP_MSB  = 19;
  localparam int OP_LSB  = 14;
  localparam int RA_MSB  = 13;
  localparam int RA_LSB  = 12;
  localparam int RB_MSB  = 11;
  localparam int RB_LSB  = 10;
  localparam int RC_MSB  = 9;
  localparam int RC_LSB  = 8;
  localparam int OFF_MSB = 9;
  localparam int IMM_MSB = 11;
  localparam int JT_MSB  = 13;
  localparam int JT_LSB  = 5;

  // Opcode 0 is deliberately illegal so that zero-filled memory traps
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_SLT  = 6'h05;
  localparam logic [5:0] OP_LDI  = 6'h08;
  localparam logic [5:0] OP_LD   = 6'h09;
  localparam logic [5:0] OP_ST   = 6'h0A;
  localparam logic [5:0] OP_BEQ  = 6'h0C;
  localparam logic [5:0] OP_J    = 6'h0D;
  localparam logic [5:0] OP_HALT = 6'h0F;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_EQ
  } alu_op_e;

  function automatic logic is_alu_op(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_SLT);
  endfunction

  function automatic logic is_legal_op(input logic [5:0] op);
    return is_alu_op(op) || (op == OP_LDI) || (op == OP_LD) || (op == OP_ST) ||
           (op == OP_BEQ) || (op == OP_J)  || (op == OP_HALT);
  endfunction

  // LD/ST use ADD for address generation, BEQ uses EQ for the compare
  function automatic alu_op_e alu_op_of(input logic [5:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_SLT:  return ALU_SLT;
      OP_BEQ:  return ALU_EQ;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - combinational ALU for mc_core (ADD/SUB/AND/OR/SLT/EQ)
//
// Ports:
//   i_op  ALU operation (alu_op_e)
//   i_a   first operand, WORD_SIZE bits
//   i_b   second operand, WORD_SIZE bits
//   o_y   result; SLT and EQ return 1 or 0 in bit 0
module mc_alu
  import mc_pkg::*;
#(
  parameter int WORD_SIZE = 64
) (
  input  alu_op_e              i_op,
  input  logic [WORD_SIZE-1:0] i_a,
  input  logic [WORD_SIZE-1:0] i_b,
  output logic [WORD_SIZE-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_op)
      ALU_ADD: o_y = i_a + i_b;
      ALU_SUB: o_y = i_a - i_b;
      ALU_AND: o_y = i_a & i_b;
      ALU_OR:  o_y = i_a | i_b;
      ALU_SLT: o_y = {{(WORD_SIZE-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_EQ:  o_y = {{(WORD_SIZE-1){1'b0}}, (i_a == i_b)};
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/mc_core.sv
// rtl/mc_core.sv - parametrised multicycle processor core with handshaked external memory
//
// FETCH/DECODE/EXEC/MEM/WB/HALT state machine executing the 20-bit instruction
// set. Optional performance counters are built when MC_PERF_EN is defined;
// otherwise cycle_cnt and retired_cnt are tied to zero.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   mem_req/mem_we   transaction request and direction (1 = write)
//   mem_addr         byte address, held while mem_req
//   mem_wdata        store data, held while mem_req && mem_we
//   mem_rdata        read data, sampled on the completing edge
//   mem_ready        completes a transaction on an edge where mem_req is high
//   halted/illegal   core stopped / stopped because of an illegal opcode
//   pc_dbg           current PC
//   cycle_cnt        cycles since reset (MC_PERF_EN)
//   retired_cnt      instructions retired (MC_PERF_EN)
module mc_core
  import mc_pkg::*;
#(
  parameter int                      WORD_SIZE    = 64,
  parameter int                      ADDRESS_SIZE = 11,
  parameter int                      NUM_REGS     = 4,
  parameter logic [ADDRESS_SIZE-1:0] RESET_PC     = ADDRESS_SIZE'(11'h400)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]    mem_wdata,
  input  logic [WORD_SIZE-1:0]    mem_rdata,
  input  logic                    mem_ready,
  output logic                    halted,
  output logic                    illegal,
  output logic [ADDRESS_SIZE-1:0] pc_dbg,
  output logic [31:0]             cycle_cnt,
  output logic [31:0]             retired_cnt
);

  state_e                      r_state;
  state_e                      w_next;
  logic [ADDRESS_SIZE-1:0]     r_pc;
  logic [INSTR_W-1:0]          r_ir;
  logic [WORD_SIZE-1:0]        r_a;
  logic [WORD_SIZE-1:0]        r_b;
  logic [WORD_SIZE-1:0]        r_alu_out;
  logic [WORD_SIZE-1:0]        r_mdr;
  logic [WORD_SIZE-1:0]        r_rf [NUM_REGS];
  logic                        r_illegal;
  logic                        r_fetch_hold;

  logic [5:0]                  w_op;
  logic [REG_ADDRESS_SIZE-1:0] w_ra;
  logic [REG_ADDRESS_SIZE-1:0] w_rb;
  logic [REG_ADDRESS_SIZE-1:0] w_rc;
  logic [WORD_SIZE-1:0]        w_off_ext;
  logic [WORD_SIZE-1:0]        w_imm_ext;
  logic [ADDRESS_SIZE-1:0]     w_br_target;
  logic [ADDRESS_SIZE-1:0]     w_jump_pc;
  logic                        w_mem_req;
  logic                        w_mem_done;
  alu_op_e                     w_alu_op;
  logic [WORD_SIZE-1:0]        w_alu_b;
  logic [WORD_SIZE-1:0]        w_alu_y;
  logic [WORD_SIZE-1:0]        w_wb_data;

  logic                        w_ir_we;
  logic                        w_ab_we;
  logic                        w_alu_we;
  logic                        w_mdr_we;
  logic                        w_rf_we;
  logic                        w_pc_we;
  logic [ADDRESS_SIZE-1:0]     w_pc_next;
  logic                        w_set_illegal;
  logic                        w_set_hold;

  assign w_op      = r_ir[OP_MSB:OP_LSB];
  assign w_ra      = r_ir[RA_MSB:RA_LSB];
  assign w_rb      = r_ir[RB_MSB:RB_LSB];
  assign w_rc      = r_ir[RC_MSB:RC_LSB];
  assign w_off_ext = {{(WORD_SIZE-10){r_ir[OFF_MSB]}}, r_ir[OFF_MSB:0]};
  assign w_imm_ext = {{(WORD_SIZE-12){r_ir[IMM_MSB]}}, r_ir[IMM_MSB:0]};

  // r_pc already holds PC+4 once the instruction has been fetched
  assign w_br_target = r_pc + {w_off_ext[ADDRESS_SIZE-3:0], 2'b00};

  always_comb begin
    w_jump_pc       = r_pc;
    w_jump_pc[10:0] = {r_ir[JT_MSB:JT_LSB], 2'b00};
  end

  // The request is decoded from the state so it appears in the first cycle
  // after reset release and vanishes the moment rst_n falls. r_fetch_hold
  // inserts the idle cycle a store needs before the next fetch request.
  assign w_mem_req  = rst_n && (((r_state == FETCH) && !r_fetch_hold) || (r_state == MEM));
  assign w_mem_done = w_mem_req && mem_ready;

  assign mem_req   = w_mem_req;
  assign mem_we    = w_mem_req && (r_state == MEM) && (w_op == OP_ST);
  assign mem_addr  = !w_mem_req ? '0 :
                     (r_state == FETCH) ? r_pc : r_alu_out[ADDRESS_SIZE-1:0];
  assign mem_wdata = mem_we ? r_b : '0;

  assign halted  = (r_state == HALT);
  assign illegal = r_illegal;
  assign pc_dbg  = r_pc;

  assign w_alu_op = alu_op_of(w_op);
  assign w_alu_b  = ((w_op == OP_LD) || (w_op == OP_ST)) ? w_off_ext : r_b;

  mc_alu #(
    .WORD_SIZE (WORD_SIZE)
  ) u_alu (
    .i_op (w_alu_op),
    .i_a  (r_a),
    .i_b  (w_alu_b),
    .o_y  (w_alu_y)
  );

  assign w_wb_data = (w_op == OP_LD)  ? r_mdr :
                     (w_op == OP_LDI) ? w_imm_ext : r_alu_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_ir_we       = 1'b0;
    w_ab_we       = 1'b0;
    w_alu_we      = 1'b0;
    w_mdr_we      = 1'b0;
    w_rf_we       = 1'b0;
    w_pc_we       = 1'b0;
    w_pc_next     = r_pc;
    w_set_illegal = 1'b0;
    w_set_hold    = 1'b0;
    case (r_state)
      FETCH: begin
        if (w_mem_done) begin
          w_ir_we   = 1'b1;
          w_pc_we   = 1'b1;
          w_pc_next = r_pc + ADDRESS_SIZE'(4);
          w_next    = DECODE;
        end
      end
      DECODE: begin
        w_ab_we = 1'b1;
        if (w_op == OP_HALT) begin
          w_next = HALT;
        end else if (!is_legal_op(w_op)) begin
          w_next        = HALT;
          w_set_illegal = 1'b1;
        end else if (w_op == OP_LDI) begin
          w_next = WB;
        end else begin
          w_next = EXEC;
        end
      end
      EXEC: begin
        w_alu_we = 1'b1;
        if (w_op == OP_BEQ) begin
          w_pc_we   = w_alu_y[0];
          w_pc_next = w_br_target;
          w_next    = FETCH;
        end else if (w_op == OP_J) begin
          w_pc_we   = 1'b1;
          w_pc_next = w_jump_pc;
          w_next    = FETCH;
        end else if ((w_op == OP_LD) || (w_op == OP_ST)) begin
          w_next = MEM;
        end else begin
          w_next = WB;
        end
      end
      MEM: begin
        if (w_mem_done) begin
          if (w_op == OP_LD) begin
            w_mdr_we = 1'b1;
            w_next   = WB;
          end else begin
            w_set_hold = 1'b1;
            w_next     = FETCH;
          end
        end
      end
      WB: begin
        w_rf_we = 1'b1;
        w_next  = FETCH;
      end
      HALT: begin
        w_next = HALT;
      end
      default: begin
        w_next = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_ir         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_alu_out    <= '0;
      r_mdr        <= '0;
      r_illegal    <= 1'b0;
      r_fetch_hold <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      r_fetch_hold <= w_set_hold;
      if (w_ir_we) begin
        r_ir <= mem_rdata[INSTR_W-1:0];
      end
      if (w_pc_we) begin
        r_pc <= w_pc_next;
      end
      if (w_ab_we) begin
        // ALU ops compare rb/rc; LD/ST/BEQ need rb as base and ra as data
        r_a <= r_rf[w_rb];
        r_b <= is_alu_op(w_op) ? r_rf[w_rc] : r_rf[w_ra];
      end
      if (w_alu_we) begin
        r_alu_out <= w_alu_y;
      end
      if (w_mdr_we) begin
        r_mdr <= mem_rdata;
      end
      if (w_rf_we) begin
        r_rf[w_ra] <= w_wb_data;
      end
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
    end
  end

`ifdef MC_PERF_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_retired_cnt;
  logic        w_retire;

  // Final edge of each instruction; illegal opcodes never retire
  assign w_retire = (r_state == WB) ||
                    ((r_state == EXEC) && ((w_op == OP_BEQ) || (w_op == OP_J))) ||
                    ((r_state == MEM) && w_mem_done && (w_op == OP_ST)) ||
                    ((r_state == DECODE) && (w_op == OP_HALT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt   <= '0;
      r_retired_cnt <= '0;
    end else begin
      if (r_cycle_cnt != '1) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
      if (w_retire) begin
        r_retired_cnt <= r_retired_cnt + 32'd1;
      end
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign retired_cnt = r_retired_cnt;
`else
  assign cycle_cnt   = '0;
  assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_core.sv
// tb/tb_mc_core.sv - directed self-checking bench for mc_core with a wait-state memory model
module tb_mc_core;

  localparam logic [5:0] T_ADD  = 6'h01;
  localparam logic [5:0] T_SUB  = 6'h02;
  localparam logic [5:0] T_AND  = 6'h03;
  localparam logic [5:0] T_OR   = 6'h04;
  localparam logic [5:0] T_SLT  = 6'h05;
  localparam logic [5:0] T_LDI  = 6'h08;
  localparam logic [5:0] T_LD   = 6'h09;
  localparam logic [5:0] T_ST   = 6'h0A;
  localparam logic [5:0] T_BEQ  = 6'h0C;
  localparam logic [5:0] T_J    = 6'h0D;
  localparam logic [5:0] T_HALT = 6'h0F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ready;
  logic        halted;
  logic        illegal;
  logic [10:0] pc_dbg;
  logic [31:0] cycle_cnt;
  logic [31:0] retired_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  logic [63:0] rom    [0:511];
  logic [63:0] wmem   [0:511];
  logic        wvalid [0:511];
  logic [10:0] rd_log [0:15];
  int          rd_n;
  int          wr_n;
  logic [10:0] wr_addr;
  logic [63:0] wr_data;
  int          wcnt;
  int          fetch_wait = 0;
  int          data_wait  = 0;

  logic        prev_stall = 1'b0;
  logic        prev_we;
  logic [10:0] prev_addr;
  logic [63:0] prev_wdata;
  int          stall_cnt = 0;
  int          stab_viol = 0;

  always #5 clk = ~clk;

  mc_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .halted      (halted),
    .illegal     (illegal),
    .pc_dbg      (pc_dbg),
    .cycle_cnt   (cycle_cnt),
    .retired_cnt (retired_cnt)
  );

  // Addresses below 0x400 are data, the rest program; each region has its own
  // wait count. Ready is also high while idle so idle-ready must be ignored.
  assign mem_ready = (wcnt >= ((mem_addr < 11'h400) ? data_wait : fetch_wait));
  assign mem_rdata = wvalid[mem_addr[10:2]] ? wmem[mem_addr[10:2]] : rom[mem_addr[10:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= 0;
      rd_n <= 0;
      wr_n <= 0;
      for (int i = 0; i < 512; i++) wvalid[i] <= 1'b0;
    end else if (mem_req && mem_ready) begin
      wcnt <= 0;
      if (mem_we) begin
        wmem[mem_addr[10:2]]   <= mem_wdata;
        wvalid[mem_addr[10:2]] <= 1'b1;
        wr_addr <= mem_addr;
        wr_data <= mem_wdata;
        wr_n    <= wr_n + 1;
      end else begin
        if (rd_n < 16) rd_log[rd_n] <= mem_addr;
        rd_n <= rd_n + 1;
      end
    end else if (mem_req) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && prev_stall) begin
      stall_cnt <= stall_cnt + 1;
      if (!mem_req || mem_we !== prev_we || mem_addr !== prev_addr || mem_wdata !== prev_wdata)
        stab_viol <= stab_viol + 1;
    end
    prev_stall <= rst_n && mem_req && !mem_ready;
    prev_we    <= mem_we;
    prev_addr  <= mem_addr;
    prev_wdata <= mem_wdata;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] enc_r(input logic [5:0] op, input logic [1:0] ra,
                                        input logic [1:0] rb, input logic [1:0] rc);
    return {44'h0, op, ra, rb, rc, 8'h00};
  endfunction

  function automatic logic [63:0] enc_i(input logic [5:0] op, input logic [1:0] ra,
                                        input logic [11:0] imm);
    return {44'h0, op, ra, imm};
  endfunction

  function automatic logic [63:0] enc_m(input logic [5:0] op, input logic [1:0] ra,
                                        input logic [1:0] rb, input logic [9:0] off);
    return {44'h0, op, ra, rb, off};
  endfunction

  function automatic logic [63:0] enc_j(input logic [5:0] op, input logic [8:0] jt);
    return {44'h0, op, jt, 5'h00};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 512; i++) rom[i] = 64'h0;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_until_halt(input int max, output int n);
    n = 0;
    while (!halted && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    int reqs;

    // Test 1: LDI/LDI/ADD/HALT with zero-wait memory, plus reset values
    clear_rom();
    rom[256] = enc_i(T_LDI, 2'd1, 12'd5);
    rom[257] = enc_i(T_LDI, 2'd2, 12'hFFD);
    rom[258] = enc_r(T_ADD, 2'd3, 2'd1, 2'd2);
    rom[259] = enc_r(T_HALT, 2'd0, 2'd0, 2'd0);
    assert_reset();
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", mem_wdata, 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_pc", 64'(pc_dbg), 64'h400);
    check("rst_cycles", 64'(cycle_cnt), 64'd0);
    check("rst_retired", 64'(retired_cnt), 64'd0);
    release_reset();
    check("t1_first_req", 64'(mem_req), 64'd1);
    check("t1_first_addr", 64'(mem_addr), 64'h400);
    run_until_halt(100, n);
    check("t1_cycles", 64'(n), 64'd12);
    check("t1_halted", 64'(halted), 64'd1);
    check("t1_illegal", 64'(illegal), 64'd0);
    check("t1_r3", dut.r_rf[3], 64'd2);
    check("t1_r2", dut.r_rf[2], 64'hFFFF_FFFF_FFFF_FFFD);
    check("t1_pc", 64'(pc_dbg), 64'h410);
`ifdef MC_PERF_EN
    check("t1_retired", 64'(retired_cnt), 64'd4);
    check("t1_cycle_ge12", 64'(cycle_cnt >= 32'd12), 64'd1);
`else
    check("t1_retired_off", 64'(retired_cnt), 64'd0);
    check("t1_cycles_off", 64'(cycle_cnt), 64'd0);
`endif
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (mem_req) reqs++;
    end
    check("t1_no_req_after_halt", 64'(reqs), 64'd0);

    // Test 2: LD/ST/LD with 3 wait states per transaction
    assert_reset();
    clear_rom();
    rom[8]   = 64'hDEAD;
    rom[256] = enc_m(T_LD, 2'd1, 2'd0, 10'h020);
    rom[257] = enc_m(T_ST, 2'd1, 2'd0, 10'h008);
    rom[258] = enc_m(T_LD, 2'd2, 2'd0, 10'h008);
    rom[259] = enc_r(T_HALT, 2'd0, 2'd0, 2'd0);
    fetch_wait = 3;
    data_wait  = 3;
    release_reset();
    run_until_halt(200, n);
    // LD 11 + ST 10 + store-to-fetch idle 1 + LD 11 + HALT 5
    check("t2_cycles", 64'(n), 64'd38);
    check("t2_writes", 64'(wr_n), 64'd1);
    check("t2_wr_addr", 64'(wr_addr), 64'h8);
    check("t2_wr_data", wr_data, 64'hDEAD);
    check("t2_r1", dut.r_rf[1], 64'hDEAD);
    check("t2_r2", dut.r_rf[2], 64'hDEAD);
    check("t2_stalls_seen", 64'(stall_cnt >= 15), 64'd1);
    check("t2_stable", 64'(stab_viol), 64'd0);

    // Test 3: SUB/AND/OR/SLT with negative operands
    assert_reset();
    clear_rom();
    fetch_wait = 0;
    data_wait  = 0;
    rom[256] = enc_i(T_LDI, 2'd1, 12'd6);
    rom[257] = enc_i(T_LDI, 2'd2, 12'hFFD);
    rom[258] = enc_r(T_SUB, 2'd3, 2'd2, 2'd1);
    rom[259] = enc_r(T_AND, 2'd0, 2'd1, 2'd2);
    rom[260] = enc_r(T_OR, 2'd1, 2'd1, 2'd2);
    rom[261] = enc_r(T_SLT, 2'd2, 2'd2, 2'd0);
    rom[262] = enc_r(T_HALT, 2'd0, 2'd0, 2'd0);
    release_reset();
    run_until_halt(100, n);
    check("t3_cycles", 64'(n), 64'd24);
    check("t3_sub", dut.r_rf[3], 64'hFFFF_FFFF_FFFF_FFF7);
    check("t3_and", dut.r_rf[0], 64'd4);
    check("t3_or", dut.r_rf[1], 64'hFFFF_FFFF_FFFF_FFFF);
    check("t3_slt_signed", dut.r_rf[2], 64'd1);

    // Test 4: BEQ taken at 0x404 with off10=-2 loops back to 0x400
    assert_reset();
    clear_rom();
    rom[256] = enc_i(T_LDI, 2'd3, 12'd1);
    rom[257] = enc_m(T_BEQ, 2'd1, 2'd2, 10'h3FE);
    release_reset();
    step(9);
    check("t4_reads", 64'(rd_n >= 3), 64'd1);
    check("t4_fetch1", 64'(rd_log[1]), 64'h404);
    check("t4_taken_target", 64'(rd_log[2]), 64'h400);
    check("t4_not_halted", 64'(halted), 64'd0);

    // Test 5: BEQ not taken falls to 0x408, then J to 0x440 and HALT
    assert_reset();
    clear_rom();
    rom[256] = enc_i(T_LDI, 2'd1, 12'd1);
    rom[257] = enc_m(T_BEQ, 2'd1, 2'd2, 10'h3FE);
    rom[258] = enc_j(T_J, 9'h110);
    rom[272] = enc_r(T_HALT, 2'd0, 2'd0, 2'd0);
    release_reset();
    run_until_halt(100, n);
    check("t5_cycles", 64'(n), 64'd11);
    check("t5_not_taken", 64'(rd_log[2]), 64'h408);
    check("t5_jump_target", 64'(rd_log[3]), 64'h440);
    check("t5_pc", 64'(pc_dbg), 64'h444);

    // Test 6: illegal opcode 6'h3F
    assert_reset();
    clear_rom();
    rom[256] = enc_r(6'h3F, 2'd0, 2'd0, 2'd0);
    release_reset();
    run_until_halt(50, n);
    check("t6_cycles", 64'(n), 64'd2);
    check("t6_halted", 64'(halted), 64'd1);
    check("t6_illegal", 64'(illegal), 64'd1);
    reqs = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (mem_req) reqs++;
    end
    check("t6_no_req", 64'(reqs), 64'd0);
`ifdef MC_PERF_EN
    check("t6_retired", 64'(retired_cnt), 64'd0);
`endif

    // Test 7: reset in the middle of a stalled LD
    assert_reset();
    clear_rom();
    rom[256] = enc_i(T_LDI, 2'd1, 12'd9);
    rom[257] = enc_m(T_LD, 2'd2, 2'd0, 10'h020);
    fetch_wait = 0;
    data_wait  = 1000;
    release_reset();
    step(9);
    check("t7_stalled_req", 64'(mem_req), 64'd1);
    check("t7_stalled_addr", 64'(mem_addr), 64'h20);
    check("t7_r1_before", dut.r_rf[1], 64'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_req_drop", 64'(mem_req), 64'd0);
    check("t7_pc", 64'(pc_dbg), 64'h400);
    check("t7_r1_cleared", dut.r_rf[1], 64'd0);
    check("t7_halted", 64'(halted), 64'd0);
    release_reset();
    check("t7_restart_req", 64'(mem_req), 64'd1);
    check("t7_restart_addr", 64'(mem_addr), 64'h400);
    step(3);
    check("t7_r1_again", dut.r_rf[1], 64'd9);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_core.md
# mc_core

Parametrised multicycle processor core: the successor of the fixed-width multicycle datapath. It executes the team's 20-bit instruction set through a FETCH/DECODE/EXEC/MEM/WB state machine. Memory is external behind a request/ready handshake that tolerates any number of wait states, and the core adds reset, halt and illegal-opcode trapping. It sits between the testbench or SoC top and a RAM model, and replaces the hard-wired RAM and testbench-forced PC.

## Interface
- WORD_SIZE, 64: register, ALU and memory data width (≥16).
- ADDRESS_SIZE, 11: byte-address width of PC and memory port.
- NUM_REGS, 4: register-file depth; must equal 2^REG_ADDRESS_SIZE (fixed 2).
- RESET_PC, 11'h400: PC value after reset.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  ADDRESS_SIZE  byte address; held stable while mem_req.
- mem_wdata  out  WORD_SIZE  store data; held stable while mem_req && mem_we.
- mem_rdata  in  WORD_SIZE  read data; sampled on the edge where mem_ready=1.
- mem_ready  in  1  transaction completes on the rising edge where mem_req && mem_ready.
- halted  out  1  core stopped (HALT opcode or illegal opcode).
- illegal  out  1  set together with halted when the stop was caused by an illegal opcode.
- pc_dbg  out  ADDRESS_SIZE  current PC.
- cycle_cnt  out  32  cycles since reset (MC_PERF_EN only).
- retired_cnt  out  32  instructions retired (MC_PERF_EN only).

## Operation
- Instruction fields, from bits [19:0] of the fetched word: op [19:14], ra [13:12], rb [11:10], rc [9:8], off10 [9:0], imm12 [11:0], jt9 [13:5].
- ADD/SUB/AND/OR/SLT: R[ra] = R[rb] op R[rc]. SLT gives 1 or 0, signed. Arithmetic wraps modulo 2^WORD_SIZE.
- LDI: R[ra] = sext(imm12).
- LD: R[ra] = mem[R[rb] + sext(off10)]. ST: mem[R[rb] + sext(off10)] = R[ra]. Addresses are truncated to ADDRESS_SIZE.
- BEQ: if R[ra]==R[rb] then PC = PC+4 + (sext(off10)<<2), else PC = PC+4.
- J: PC = {PC[msb:11], jt9<<2} zero-extended to ADDRESS_SIZE. HALT: enter HALT state.
- All other opcodes: enter HALT and set illegal=1.
- States and transitions:
  - FETCH: issue read at PC, wait for ready, latch IR, PC = PC+4.
  - DECODE: read the register file into A/B latches. Next state is EXEC, or WB for LDI, or HALT.
  - EXEC: ALU operation into ALUOut. BEQ and J update PC here and go to FETCH. LD and ST go to MEM; ALU ops go to WB.
  - MEM: issue the transaction at ALUOut and wait for ready. LD goes to WB; ST goes to FETCH.
  - WB: write the register file, then go to FETCH.
  - HALT: terminal until reset.
- retired_cnt increments on the final edge of each instruction, including HALT; illegal opcodes do not count.
- Register file resets to all zero. All registers are writable; no hard-wired zero register.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, illegal=0, pc_dbg=RESET_PC, counters=0, state=FETCH.
- mem_req rises in the first cycle after rst_n deasserts.
- Zero-wait memory (ready tied 1) gives these cycle counts: ALU ops 4, LDI 3, LD 5, ST 4, BEQ/J 3, HALT 2 to halted=1. Each wait cycle adds 1.
- mem_req, mem_we, mem_addr and mem_wdata must not change while mem_req=1 && mem_ready=0.
- mem_req drops on the edge that completes a transaction. Back-to-back transactions need at least one cycle with mem_req=0.
- mem_ready while mem_req=0 is ignored.
- rst_n asserted mid-transaction aborts it immediately; mem_req drops asynchronously.
- The PC wraps modulo 2^ADDRESS_SIZE.

## Configuration
- MC_PERF_EN defined: cycle_cnt increments every cycle except during reset, saturating at 2^32-1. retired_cnt behaves as above.
- Undefined: both counters are tied to 0 and no counter flops are synthesised. The ports always exist.

## Structure
- Package mc_pkg holds the opcode localparams, the state enum (FETCH, DECODE, EXEC, MEM, WB, HALT), the field-position constants and the ALU-op encoding.
- One sub-module, mc_alu, holds the combinational ALU (ADD/SUB/AND/OR/SLT/EQ), parametrised by WORD_SIZE. The FSM, register file and latches stay in mc_core.

## Test plan
- Reset with ready=1 and memory at 0x400 = LDI r1,5; LDI r2,-3; ADD r3,r1,r2; HALT → r3=2, halted=1 after 3+3+4+2=12 cycles, illegal=0.
- ST r1,[r0+8] then LD r2,[r0+8], with r1=0xDEAD and ready delayed 3 cycles per transaction → the write is seen at addr 8 with wdata 0xDEAD, r2=0xDEAD, and address/data are stable during the wait.
- BEQ taken with r1=r2 and off10=-2 at PC 0x404 → next fetch address 0x400. Not taken → 0x408.
- Opcode 6'h3F → halted=1 and illegal=1, with no further mem_req.
- rst_n pulsed low during a stalled LD → mem_req=0 at once, pc_dbg=0x400, registers 0, and fetch restarts.
- With MC_PERF_EN, the first test gives retired_cnt=4 and cycle_cnt≥12. Without it, both read 0.
